// File: rtl/mem_bank_arbiter.sv
// Two-lane round-robin arbiter with bounded lock bursts in front of one data-memory bank.
// Optional grant statistics are built when ARB_STATS_EN is defined.
module mem_bank_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic              Lock0,
    input  logic              Lock1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WrData0,
    input  logic [DATA_W-1:0] WrData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic [DATA_W-1:0] RdData0,
    output logic [DATA_W-1:0] RdData1,
    output logic              RdValid0,
    output logic              RdValid1,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
`ifdef ARB_STATS_EN
    ,
    input  logic              StatsClr,
    output logic [15:0]       GntCount0,
    output logic [15:0]       GntCount1
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Last counter value that may still extend a locked burst by one grant.
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic              last_r;
    logic              last_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              rd0_s;
    logic              rd1_s;
    logic              rd_valid0_r;
    logic              rd_valid1_r;
    logic [DATA_W-1:0] rd_data0_r;
    logic [DATA_W-1:0] rd_data1_r;

    // Next-state, burst counter and round-robin pointer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (Req0 && Req1) begin
                    state_s = last_r ? ST_OWN0 : ST_OWN1;
                end else if (Req0) begin
                    state_s = ST_OWN0;
                end else if (Req1) begin
                    state_s = ST_OWN1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (Req0 && Lock0 && (cnt_r < BURST_LAST)) begin
                    state_s = ST_OWN0;
                    cnt_s   = cnt_r + CNT_W'(1);
                end else if (Req1) begin
                    state_s = ST_OWN1;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (Req0) begin
                    state_s = ST_OWN0;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            ST_OWN1: begin
                if (Req1 && Lock1 && (cnt_r < BURST_LAST)) begin
                    state_s = ST_OWN1;
                    cnt_s   = cnt_r + CNT_W'(1);
                end else if (Req0) begin
                    state_s = ST_OWN0;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (Req1) begin
                    state_s = ST_OWN1;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
        if (state_s == ST_OWN0) begin
            last_s = 1'b0;
        end else if (state_s == ST_OWN1) begin
            last_s = 1'b1;
        end else begin
            last_s = last_r;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            last_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
        end
    end

    assign Gnt0 = (state_r == ST_OWN0);
    assign Gnt1 = (state_r == ST_OWN1);

    // Bank drive from the granted lane; strobes are also gated by reset.
    always_comb begin
        MemAddress   = {ADDR_W{1'b0}};
        MemWriteData = {DATA_W{1'b0}};
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        case (state_r)
            ST_OWN0: begin
                MemAddress   = Addr0;
                MemWriteData = WrData0;
                MemWrite     = Rst_n & Req0 & We0;
                MemRead      = Rst_n & Req0 & ~We0;
            end
            ST_OWN1: begin
                MemAddress   = Addr1;
                MemWriteData = WrData1;
                MemWrite     = Rst_n & Req1 & We1;
                MemRead      = Rst_n & Req1 & ~We1;
            end
            default: begin
                MemAddress   = {ADDR_W{1'b0}};
                MemWriteData = {DATA_W{1'b0}};
                MemWrite     = 1'b0;
                MemRead      = 1'b0;
            end
        endcase
    end

    assign rd0_s = MemRead & Gnt0;
    assign rd1_s = MemRead & Gnt1;

    // Read-data capture; data holds until the lane's next read.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_valid0_r <= 1'b0;
            rd_valid1_r <= 1'b0;
            rd_data0_r  <= {DATA_W{1'b0}};
            rd_data1_r  <= {DATA_W{1'b0}};
        end else begin
            rd_valid0_r <= rd0_s;
            rd_valid1_r <= rd1_s;
            if (rd0_s) begin
                rd_data0_r <= MemReadData;
            end
            if (rd1_s) begin
                rd_data1_r <= MemReadData;
            end
        end
    end

    assign RdValid0 = rd_valid0_r;
    assign RdValid1 = rd_valid1_r;
    assign RdData0  = rd_data0_r;
    assign RdData1  = rd_data1_r;

`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0_r;
    logic [15:0] gnt_cnt1_r;

    // Saturating grant counters; clear has priority over counting.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gnt_cnt0_r <= 16'h0000;
            gnt_cnt1_r <= 16'h0000;
        end else if (StatsClr) begin
            gnt_cnt0_r <= 16'h0000;
            gnt_cnt1_r <= 16'h0000;
        end else begin
            if (Gnt0 && Req0 && (gnt_cnt0_r != 16'hFFFF)) begin
                gnt_cnt0_r <= gnt_cnt0_r + 16'h0001;
            end
            if (Gnt1 && Req1 && (gnt_cnt1_r != 16'hFFFF)) begin
                gnt_cnt1_r <= gnt_cnt1_r + 16'h0001;
            end
        end
    end

    assign GntCount0 = gnt_cnt0_r;
    assign GntCount1 = gnt_cnt1_r;
`endif

endmodule

// File: doc/mem_bank_arbiter.md
Name: mem_bank_arbiter

Overview:
- Two-requester round-robin arbiter in front of one 256x8 data-memory bank (sync write, combinational read when MemRead=1, else 0).
- Lets two processing lanes share one bank. Each grant is one access.
- Read data is registered back to the winner one cycle after its grant.
- A Lock input allows bounded back-to-back bursts.

Parameters:
- ADDR_W, 8, bank address width
- DATA_W, 8, bank data width
- MAX_BURST, 4, max consecutive grants to one locked requester (>=1)
- CNT_W, 2, burst counter width, >= clog2(MAX_BURST)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Req0 / Req1  in  1  access request, lanes 0/1
- We0 / We1  in  1  1=write, 0=read
- Lock0 / Lock1  in  1  request to keep grant next cycle
- Addr0 / Addr1  in  ADDR_W  access address
- WrData0 / WrData1  in  DATA_W  write data
- Gnt0 / Gnt1  out  1  registered grant; access performed this cycle
- RdData0 / RdData1  out  DATA_W  captured read data
- RdValid0 / RdValid1  out  1  one-cycle pulse, RdDataN valid
- MemAddress  out  ADDR_W  to bank Address
- MemWriteData  out  DATA_W  to bank WriteData
- MemWrite / MemRead  out  1  to bank strobes
- MemReadData  in  DATA_W  from bank ReadData

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE; Gnt*=0, RdValid*=0, RdData*=0
  - LastServed=1, so lane 0 wins the first tie; BurstCnt=0
  - MemWrite=MemRead=0
- FSM states: IDLE, OWN0, OWN1. GntN = (state==OWNN), decoded from the state register.
- Next state, evaluated each edge:
  - IDLE: both Req -> OWN of lane != LastServed; single Req -> that lane; none -> IDLE.
  - OWNi: Req_i & Lock_i & BurstCnt<MAX_BURST-1 -> OWNi, BurstCnt+1.
  - OWNi, else if Req_other -> OWN_other, BurstCnt=0.
  - OWNi, else if Req_i -> OWNi, BurstCnt=0 (new burst).
  - OWNi, else -> IDLE, BurstCnt=0.
  - Every entry into OWNi, including a stay that resets BurstCnt, sets LastServed=i.
- Bank drive (combinational from state and the granted lane's inputs):
  - MemAddress / MemWriteData = granted lane's Addr / WrData; 0 in IDLE.
  - MemWrite = Gnt_i & Req_i & We_i.
  - MemRead = Gnt_i & Req_i & ~We_i.
  - Req dropped in a grant cycle: no access, no RdValid.
- Latency:
  - Req seen at edge t -> Gnt high in cycle t+1.
  - Write lands at the end of the grant cycle.
  - Read: MemReadData captured into RdData_i at the end of the grant cycle; RdValid_i pulses in the following cycle.
  - RdData_i holds its value until the next read for that lane.
- Requester contract: hold Req/We/Addr/WrData stable until Gnt is seen. Each Gnt cycle consumes exactly one access. Requester updates Addr for the next beat in the cycle after Gnt.
- Fairness: a lane with Req held waits at most MAX_BURST grant cycles.
- Simultaneous events: both lanes locked -> the owner keeps its grant to the burst limit, then hands over.
- Reset mid-burst: grant and any pending RdValid are dropped immediately; no bank strobe while Rst_n=0.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs GntCount0 / GntCount1 (16 bits each): count cycles where Gnt_i & Req_i.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Adds input StatsClr (1 bit): synchronous clear to 0; clear wins over increment.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset then Req0=1, We0=1, Addr0=8'h10, WrData0=8'hA5 -> Gnt0 in cycle 1, MemWrite=1 at addr 8'h10. Then read 8'h10 -> RdValid0 pulse, RdData0=8'hA5.
- Req0=Req1=1 held, no lock, reads -> grants alternate 0,1,0,1; lane 0 first after reset; MemRead every cycle; RdValid alternates one cycle after each Gnt.
- Lock0=1, Req0, Req1 held, MAX_BURST=4 -> Gnt0 for exactly 4 cycles, then Gnt1. Lane 1 then keeps the grant one cycle only, unless Lock1.
- Req0 only, Lock0=0, held 6 cycles -> Gnt0 continuous 6 cycles, BurstCnt stays 0. Req0 deasserted in a grant cycle -> no MemRead/MemWrite and no RdValid0; state IDLE next cycle.
- Rst_n asserted low during lane-1 read grant -> Gnt1, RdValid1 and MemRead go 0 immediately. After release, a tie grants lane 0 first.
- With ARB_STATS_EN: 3 grants to lane 0, 5 to lane 1 -> GntCount0=3, GntCount1=5. StatsClr held during a grant -> both counters read 0.
